// File: rtl/shared_unit_rr_arbiter_pkg.sv
// Shared definitions for the round-robin front end of a shared arithmetic unit:
// width helpers and the round-robin pick function.

`ifndef SHARED_UNIT_RR_ARBITER_MACROS
`define SHARED_UNIT_RR_ARBITER_MACROS
// Tag / pointer width: at least one bit even for two entries.
`define SURA_TAG_W(n) (((n) > 32'sd2) ? shared_unit_rr_arbiter_pkg::f_clog2(n) : 32'sd1)
// Occupancy counter width: must be able to hold the value m itself.
`define SURA_CNT_W(m) (shared_unit_rr_arbiter_pkg::f_clog2((m) + 32'sd1))
`endif

package shared_unit_rr_arbiter_pkg;

    // Upper bound on requester count handled by rr_pick.
    localparam int MAX_N = 32;

    // Ceiling log2 usable in constant expressions.
    function automatic int f_clog2(input int i_val);
        int v_res;
        int v_pow;
        v_res = 32'sd0;
        v_pow = 32'sd1;
        for (int i = 0; i < 31; i++) begin
            if (v_pow < i_val) begin
                v_pow = v_pow * 32'sd2;
                v_res = v_res + 32'sd1;
            end else begin
                v_res = v_res;
            end
        end
        return v_res;
    endfunction

    // Round-robin pick: mask off requesters below i_ptr, priority-encode the
    // masked set, fall back to the unmasked set when nothing is left above i_ptr.
    function automatic logic [31:0] rr_pick(input logic [MAX_N-1:0] i_req,
                                            input logic [31:0]      i_n,
                                            input logic [31:0]      i_ptr);
        logic [MAX_N-1:0] v_valid;
        logic [MAX_N-1:0] v_masked;
        logic [31:0]      v_sel;
        logic             v_found;
        for (int i = 0; i < MAX_N; i++) begin
            v_valid[i]  = i_req[i] & (32'(i) < i_n);
            v_masked[i] = i_req[i] & (32'(i) < i_n) & (32'(i) >= i_ptr);
        end
        if (v_masked == {MAX_N{1'b0}}) begin
            v_masked = v_valid;
        end else begin
            v_masked = v_masked;
        end
        v_sel   = i_ptr;
        v_found = 1'b0;
        for (int i = 0; i < MAX_N; i++) begin
            if (v_masked[i] && !v_found) begin
                v_sel   = 32'(i);
                v_found = 1'b1;
            end else begin
                v_found = v_found;
            end
        end
        return v_sel;
    endfunction

endpackage

// File: rtl/shared_unit_rr_arbiter_if.sv
// Bundle of the requester-side and unit-side handshake channels.
// slave: the arbiter. master: the surrounding producers, consumers and unit.

interface shared_unit_rr_arbiter_if #(
    parameter int NUM_INPUTS  = 2,
    parameter int INPUT_TYPE  = 32,
    parameter int OUTPUT_TYPE = 32
);
    logic [NUM_INPUTS*INPUT_TYPE-1:0]  ins;
    logic [NUM_INPUTS-1:0]             ins_valid;
    logic [NUM_INPUTS-1:0]             ins_ready;
    logic [NUM_INPUTS*OUTPUT_TYPE-1:0] outs;
    logic [NUM_INPUTS-1:0]             outs_valid;
    logic [NUM_INPUTS-1:0]             outs_ready;
    logic [INPUT_TYPE-1:0]             unit_ins;
    logic                              unit_ins_valid;
    logic                              unit_ins_ready;
    logic [OUTPUT_TYPE-1:0]            unit_outs;
    logic                              unit_outs_valid;
    logic                              unit_outs_ready;

    modport slave (
        input  ins, ins_valid, outs_ready, unit_ins_ready, unit_outs, unit_outs_valid,
        output ins_ready, outs, outs_valid, unit_ins, unit_ins_valid, unit_outs_ready
    );

    modport master (
        output ins, ins_valid, outs_ready, unit_ins_ready, unit_outs, unit_outs_valid,
        input  ins_ready, outs, outs_valid, unit_ins, unit_ins_valid, unit_outs_ready
    );
endinterface

// File: rtl/shared_unit_rr_arbiter_tag_fifo.sv
// Register-based FIFO holding the requester index of every operand issued to
// the unit, so results can be routed back in order. Depth need not be 2^n.

module shared_unit_rr_arbiter_tag_fifo
    import shared_unit_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = `SURA_TAG_W(DEPTH);
    localparam int CNT_W = `SURA_CNT_W(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointer increment with wrap at DEPTH.
    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] i_ptr);
        return (i_ptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : (i_ptr + PTR_W'(32'd1));
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == {CNT_W{1'b0}});
    assign w_do_push = i_push & ~o_full;   // no write-through when full
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rptr];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= f_next(r_wptr);
            end
            if (w_do_pop) begin
                r_rptr <= f_next(r_rptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(32'd1);
                2'b01:   r_count <= r_count - CNT_W'(32'd1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/shared_unit_rr_arbiter.sv
// Shares one in-order pipelined arithmetic unit between NUM_INPUTS requesters.
// Operands are granted round-robin; a grant is locked while the unit stalls so
// the presented operand stays stable. Grant order is logged in a tag FIFO and
// results are steered back to the requester at its head. Zero added latency.

module shared_unit_rr_arbiter
    import shared_unit_rr_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS   = 2,
    parameter int INPUT_TYPE   = 32,
    parameter int OUTPUT_TYPE  = 32,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    shared_unit_rr_arbiter_if.slave    bus
);
    localparam int TAG_W = `SURA_TAG_W(NUM_INPUTS);

    logic [TAG_W-1:0]      r_rr_ptr;
    logic                  r_lock;
    logic [TAG_W-1:0]      r_lock_idx;

    logic [TAG_W-1:0]      w_gnt;
    logic                  w_any;
    logic                  w_full;
    logic                  w_empty;
    logic [TAG_W-1:0]      w_head;
    logic                  w_unit_ins_valid;
    logic                  w_issue;
    logic                  w_pop;
    logic [INPUT_TYPE-1:0] w_unit_ins;
    logic [NUM_INPUTS-1:0] w_ins_ready;
    logic [NUM_INPUTS-1:0] w_outs_valid;
    logic                  w_head_ready;
    logic                  w_unit_outs_ready;

    // Grant selection: a locked grant wins over round-robin.
    always_comb begin
        w_gnt = TAG_W'(rr_pick(MAX_N'(bus.ins_valid), 32'(NUM_INPUTS), 32'(r_rr_ptr)));
        if (r_lock) begin
            w_gnt = r_lock_idx;
        end else begin
            w_gnt = w_gnt;
        end
    end

    // Issue side: operand mux and per-requester ready.
    always_comb begin
        w_any            = |bus.ins_valid;
        w_unit_ins_valid = w_any & ~w_full;
        w_issue          = w_unit_ins_valid & bus.unit_ins_ready;
        w_unit_ins       = {INPUT_TYPE{1'b0}};
        w_ins_ready      = {NUM_INPUTS{1'b0}};
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (TAG_W'(i) == w_gnt) begin
                w_unit_ins     = bus.ins[i*INPUT_TYPE +: INPUT_TYPE];
                w_ins_ready[i] = w_issue;
            end else begin
                w_ins_ready[i] = 1'b0;
            end
        end
    end

    // Return side: steer the unit result to the requester at the FIFO head.
    always_comb begin
        w_outs_valid = {NUM_INPUTS{1'b0}};
        w_head_ready = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (TAG_W'(i) == w_head) begin
                w_outs_valid[i] = bus.unit_outs_valid & ~w_empty;
                w_head_ready    = bus.outs_ready[i];
            end else begin
                w_outs_valid[i] = 1'b0;
            end
        end
        w_unit_outs_ready = ~w_empty & w_head_ready;
        w_pop             = bus.unit_outs_valid & w_unit_outs_ready;
    end

    assign bus.unit_ins        = w_unit_ins;
    assign bus.unit_ins_valid  = w_unit_ins_valid;
    assign bus.ins_ready       = w_ins_ready;
    assign bus.outs            = {NUM_INPUTS{bus.unit_outs}};
    assign bus.outs_valid      = w_outs_valid;
    assign bus.unit_outs_ready = w_unit_outs_ready;

    // Round-robin pointer and stall lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= {TAG_W{1'b0}};
            r_lock     <= 1'b0;
            r_lock_idx <= {TAG_W{1'b0}};
        end else if (w_issue) begin
            r_lock   <= 1'b0;
            r_rr_ptr <= (w_gnt == TAG_W'(NUM_INPUTS - 1)) ? {TAG_W{1'b0}} : (w_gnt + TAG_W'(32'd1));
        end else if (w_unit_ins_valid) begin
            // Unit stalled: freeze the grant so the operand cannot change.
            r_lock     <= 1'b1;
            r_lock_idx <= w_gnt;
        end else begin
            r_lock     <= r_lock;
            r_lock_idx <= r_lock_idx;
        end
    end

    shared_unit_rr_arbiter_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_issue),
        .i_din   (w_gnt),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_shared_unit_rr_arbiter.sv
// Bench for shared_unit_rr_arbiter: two requesters, a 1-cycle in-order unit
// model f(x) = 3x + 1, and per-requester result scoreboards.

module tb_shared_unit_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shared_unit_rr_arbiter_if #(.NUM_INPUTS(2), .INPUT_TYPE(32), .OUTPUT_TYPE(32)) bus_if ();

    shared_unit_rr_arbiter #(
        .NUM_INPUTS   (2),
        .INPUT_TYPE   (32),
        .OUTPUT_TYPE  (32),
        .MAX_INFLIGHT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int          n_checks = 0;
    int          n_pass   = 0;

    logic [31:0] src_q [2][$];
    logic [31:0] exp_q [2][$];
    logic [31:0] unit_q [$];
    int          grant_log [$];

    logic        unit_rdy_v = 1'b1;
    logic        ret_en_v   = 1'b1;
    logic        force_uv_v = 1'b0;
    logic [1:0]  oready_v   = 2'b11;

    logic [1:0]  in_fire;
    logic        uin_fire;
    logic        uout_fire;
    logic [31:0] uin_s;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] unit_f(input logic [31:0] x);
        return x * 32'd3 + 32'd1;
    endfunction

    task automatic send(input int r, input logic [31:0] op);
        src_q[r].push_back(op);
        exp_q[r].push_back(unit_f(op));
    endtask

    function automatic logic all_empty();
        return (src_q[0].size() == 0) && (src_q[1].size() == 0) &&
               (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && (unit_q.size() == 0);
    endfunction

    // Drive inputs at negedge, sample outputs 1 time unit later, score returns.
    task automatic drive_sample();
        int g;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bus_if.ins_valid[i]      = (src_q[i].size() > 0);
            bus_if.ins[i*32 +: 32]   = (src_q[i].size() > 0) ? src_q[i][0] : 32'd0;
        end
        bus_if.unit_ins_ready = unit_rdy_v;
        if (ret_en_v && unit_q.size() > 0) begin
            bus_if.unit_outs_valid = 1'b1;
            bus_if.unit_outs       = unit_q[0];
        end else begin
            bus_if.unit_outs_valid = force_uv_v;
            bus_if.unit_outs       = 32'hDEAD_BEEF;
        end
        bus_if.outs_ready = oready_v;
        #1;
        in_fire   = bus_if.ins_valid & bus_if.ins_ready;
        uin_fire  = bus_if.unit_ins_valid & bus_if.unit_ins_ready;
        uout_fire = bus_if.unit_outs_valid & bus_if.unit_outs_ready & (unit_q.size() > 0);
        uin_s     = bus_if.unit_ins;
        if (uin_fire) begin
            g = 0;
            for (int i = 0; i < 2; i++) if (in_fire[i]) g = i;
            check_val("ready_onehot", 64'($countones(in_fire)), 64'd1);
            if (src_q[g].size() > 0) check_val("uin_op", uin_s, src_q[g][0]);
            else check_val("uin_nosrc", 64'd1, 64'd0);
            grant_log.push_back(g);
        end
        for (int i = 0; i < 2; i++) begin
            if (bus_if.outs_valid[i] && bus_if.outs_ready[i]) begin
                if (exp_q[i].size() == 0) check_val("ret_unexp", 64'd1, 64'd0);
                else check_val($sformatf("ret_data%0d", i), bus_if.outs[i*32 +: 32], exp_q[i].pop_front());
            end
        end
    endtask

    // Commit the handshakes sampled in drive_sample to the models.
    task automatic advance();
        @(posedge clk);
        for (int i = 0; i < 2; i++) if (in_fire[i]) void'(src_q[i].pop_front());
        if (uout_fire) void'(unit_q.pop_front());
        if (uin_fire) unit_q.push_back(unit_f(uin_s));
    endtask

    task automatic cycle();
        drive_sample();
        advance();
    endtask

    task automatic drain();
        unit_rdy_v = 1'b1; ret_en_v = 1'b1; oready_v = 2'b11; force_uv_v = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (all_empty()) break;
            cycle();
        end
        check_val("drain", 64'(all_empty()), 64'd1);
    endtask

    initial begin
        int g4 [4];
        bus_if.ins = 64'd0; bus_if.ins_valid = 2'b00; bus_if.outs_ready = 2'b11;
        bus_if.unit_ins_ready = 1'b1; bus_if.unit_outs = 32'd0; bus_if.unit_outs_valid = 1'b0;
        in_fire = 2'b00; uin_fire = 1'b0; uout_fire = 1'b0; uin_s = 32'd0;

        // Reset and idle
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            drive_sample();
            check_val("rst_idle", {bus_if.unit_ins_valid, bus_if.ins_ready, bus_if.outs_valid, bus_if.unit_outs_ready}, 64'd0);
            advance();
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_sample();
            check_val("idle", {bus_if.unit_ins_valid, bus_if.ins_ready, bus_if.outs_valid, bus_if.unit_outs_ready}, 64'd0);
            advance();
        end

        // Alternating grants with both requesters valid
        grant_log.delete();
        send(0, 32'hA); send(1, 32'hB); send(0, 32'h1A); send(1, 32'h1B);
        for (int k = 0; k < 4; k++) cycle();
        for (int k = 0; k < 4; k++) g4[k] = (k < grant_log.size()) ? grant_log[k] : 99;
        check_val("alt_cnt", 64'(grant_log.size()), 64'd4);
        check_val("alt_g0", 64'(g4[0]), 64'd0);
        check_val("alt_g1", 64'(g4[1]), 64'd1);
        check_val("alt_g2", 64'(g4[2]), 64'd0);
        check_val("alt_g3", 64'(g4[3]), 64'd1);
        drain();

        // Lock: unit stalls on req1, req0 appears while stalled
        unit_rdy_v = 1'b0;
        send(1, 32'h11);
        drive_sample();
        check_val("lock_c1", {bus_if.unit_ins_valid, bus_if.unit_ins}, {1'b1, 32'h11});
        advance();
        send(0, 32'h22);
        drive_sample();
        check_val("lock_c2", {bus_if.unit_ins_valid, bus_if.unit_ins}, {1'b1, 32'h11});
        advance();
        drive_sample();
        check_val("lock_c3", {bus_if.unit_ins_valid, bus_if.unit_ins}, {1'b1, 32'h11});
        advance();
        unit_rdy_v = 1'b1;
        drive_sample();
        check_val("lock_acc1", 64'(bus_if.ins_ready), 64'h2);
        advance();
        drive_sample();
        check_val("lock_acc0", {bus_if.ins_ready, bus_if.unit_ins}, {2'b01, 32'h22});
        advance();
        drain();

        // Full: unit never returns until one pop is allowed
        ret_en_v = 1'b0;
        for (int k = 0; k < 5; k++) send(0, 32'h100 + 32'(k));
        for (int k = 0; k < 4; k++) begin
            drive_sample();
            check_val("full_fill", 64'(bus_if.ins_ready), 64'h1);
            advance();
        end
        ret_en_v = 1'b1;
        drive_sample();
        check_val("full_block", {bus_if.unit_ins_valid, bus_if.ins_ready}, 64'd0);
        check_val("full_pop", 64'(bus_if.unit_outs_ready), 64'd1);
        advance();
        ret_en_v = 1'b0;
        drive_sample();
        check_val("full_reissue", {bus_if.unit_ins_valid, bus_if.ins_ready}, {1'b1, 2'b01});
        advance();
        drive_sample();
        check_val("full_again", 64'(bus_if.unit_ins_valid), 64'd0);
        advance();
        drain();

        // Back-pressure on the head requester
        ret_en_v = 1'b0;
        send(1, 32'h33);
        drive_sample();
        check_val("bp_iss1", 64'(bus_if.ins_ready), 64'h2);
        advance();
        send(0, 32'h44);
        drive_sample();
        check_val("bp_iss0", 64'(bus_if.ins_ready), 64'h1);
        advance();
        ret_en_v = 1'b1; oready_v = 2'b01;
        for (int k = 0; k < 2; k++) begin
            drive_sample();
            check_val("bp_hold", {bus_if.outs_valid, bus_if.unit_outs_ready}, {2'b10, 1'b0});
            check_val("bp_data", bus_if.outs[63:32], unit_f(32'h33));
            advance();
        end
        oready_v = 2'b11;
        drive_sample();
        check_val("bp_release", 64'(bus_if.unit_outs_ready), 64'd1);
        advance();
        oready_v = 2'b00;
        drive_sample();
        check_val("bp_next_head", 64'(bus_if.outs_valid), 64'h1);
        advance();
        drain();

        // Reset with three operands in flight
        ret_en_v = 1'b0;
        for (int k = 0; k < 3; k++) send(0, 32'h200 + 32'(k));
        for (int k = 0; k < 3; k++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        unit_q.delete();
        for (int i = 0; i < 2; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        send(0, 32'h55); send(1, 32'h66);
        force_uv_v = 1'b1;
        drive_sample();
        check_val("rst_outs", {bus_if.outs_valid, bus_if.unit_outs_ready}, 64'd0);
        check_val("rst_ptr", 64'(bus_if.ins_ready), 64'h1);
        advance();
        force_uv_v = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
